apb_gpio_slave: RTL

//  APB3 completer providing a WIDTH-bit GPIO port with edge interrupts; one of the slaves the APB master addresses.

---
 rtl/apb_gpio_pkg.sv | 18 +
 rtl/apb_gpio_slave_sync_edge.sv | 45 ++++
 rtl/apb_gpio_slave.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/apb_gpio_pkg.sv
// Register offsets and APB completer FSM states shared by the GPIO slave files.
package apb_gpio_pkg;

  localparam logic [31:0] OFF_DOUT = 32'h00;
  localparam logic [31:0] OFF_DIR  = 32'h04;
  localparam logic [31:0] OFF_DIN  = 32'h08;
  localparam logic [31:0] OFF_IEN  = 32'h0C;
  localparam logic [31:0] OFF_STAT = 32'h10;
  localparam logic [31:0] OFF_EDGE = 32'h14;
  localparam logic [31:0] LAST_OFF = 32'h14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_gpio_slave_sync_edge.sv
// gpio_sync_edge: 2-flop pad synchronizer (2-cycle latency, no backpressure) plus per-bit edge events.
// The prev flop and event logic exist only when GPIO_IRQ_EN is defined; otherwise o_event is 0.
module gpio_sync_edge #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  input  logic [WIDTH-1:0] i_edge_sel,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_event
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= r_sync;
  end

  // edge_sel=1 selects falling, 0 selects rising
  assign o_event = (i_edge_sel & ~r_sync & r_prev) | (~i_edge_sel & r_sync & ~r_prev);
`else
  logic w_unused_sel;
  assign w_unused_sel = ^i_edge_sel;
  assign o_event      = '0;
`endif

endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 GPIO completer: 2+WAIT_CYCLES cycles from setup to PREADY, wait states via PREADY low.
// Edge detect, IRQ_EN/IRQ_STAT/EDGE_SEL registers and irq are built only with GPIO_IRQ_EN defined.
module apb_gpio_slave #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);
  import apb_gpio_pkg::*;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
  logic [WIDTH-1:0] r_ien, r_stat, r_edge, w_clr;
  logic             r_irq;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif

  apb_state_e       r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_dout, r_dir, w_din, w_event, w_edge_sel;
  logic [31:0]      w_addr, w_rdata;
  logic             w_ready, w_err, w_irq_off, w_wr_en;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE:   if (PSEL && !PENABLE) w_state_nxt = SETUP;
      SETUP: begin
        w_state_nxt = ACCESS;
        w_cnt_nxt   = 4'(WAIT_CYCLES);
      end
      ACCESS: begin
        if (!PSEL)              w_state_nxt = IDLE;
        else if (r_cnt == 4'd0) w_state_nxt = PENABLE ? IDLE : SETUP;
        else                    w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ready   = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_addr    = 32'(PADDR);
  assign w_irq_off = (w_addr == OFF_IEN) || (w_addr == OFF_STAT) || (w_addr == OFF_EDGE);
  assign w_err     = (|PADDR[1:0]) || (w_addr > LAST_OFF) || (PWRITE && (w_addr == OFF_DIN)) ||
                     (!IRQ_IMPL && w_irq_off);
  assign w_wr_en   = PSEL && PENABLE && PWRITE && w_ready && !w_err;

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready && w_err;
  assign PRDATA  = (w_ready && !PWRITE && !w_err) ? w_rdata : 32'h0;

  always_comb begin
    w_rdata = 32'h0;
    case (w_addr)
      OFF_DOUT: w_rdata = 32'(r_dout);
      OFF_DIR:  w_rdata = 32'(r_dir);
      OFF_DIN:  w_rdata = 32'(w_din);
`ifdef GPIO_IRQ_EN
      OFF_IEN:  w_rdata = 32'(r_ien);
      OFF_STAT: w_rdata = 32'(r_stat);
      OFF_EDGE: w_rdata = 32'(r_edge);
`endif
      default:  w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_dout <= '0;
      r_dir  <= '0;
    end else if (w_wr_en) begin
      if (w_addr == OFF_DOUT) r_dout <= PWDATA[WIDTH-1:0];
      if (w_addr == OFF_DIR)  r_dir  <= PWDATA[WIDTH-1:0];
    end
  end

  assign gpio_out = r_dout;
  assign gpio_oe  = r_dir;

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .i_async    (gpio_in),
    .i_edge_sel (w_edge_sel),
    .o_sync     (w_din),
    .o_event    (w_event)
  );

`ifdef GPIO_IRQ_EN
  assign w_clr = (w_wr_en && (w_addr == OFF_STAT)) ? PWDATA[WIDTH-1:0] : '0;

  // an event arriving on the same edge as its W1C wins over the clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ien  <= '0;
      r_stat <= '0;
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_en && (w_addr == OFF_IEN))  r_ien  <= PWDATA[WIDTH-1:0];
      if (w_wr_en && (w_addr == OFF_EDGE)) r_edge <= PWDATA[WIDTH-1:0];
      r_stat <= (r_stat & ~w_clr) | w_event;
      r_irq  <= |(r_stat & r_ien);
    end
  end

  assign w_edge_sel = r_edge;
  assign irq        = r_irq;
`else
  logic w_unused_event;
  assign w_unused_event = |w_event;
  assign w_edge_sel     = '0;
  assign irq            = 1'b0;
`endif

endmodule
